// File: rtl/mult_eval_pkg.sv
// rtl/mult_eval_pkg.sv - shared widths, FSM states and stage-1 record for multiplier evaluation
package mult_eval_pkg;

  localparam int OP_W = 8;
  localparam int P_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic            valid;
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic [P_W-1:0]  ed;
  } stage1_t;

  // 17-bit signed subtract so the magnitude of any 16-bit difference fits in P_W bits
  function automatic logic [P_W-1:0] abs_diff(input logic [P_W-1:0] x,
                                               input logic [P_W-1:0] y);
    logic signed [P_W:0] d;
    d = $signed({1'b0, x}) - $signed({1'b0, y});
    if (d < 0) d = -d;
    return d[P_W-1:0];
  endfunction

endpackage

// File: rtl/mult_ed_stage.sv
// rtl/mult_ed_stage.sv - registered error-distance stage with operand capture and valid flag
import mult_eval_pkg::*;

module mult_ed_stage (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  input  logic [P_W-1:0]  p_exact,
  input  logic [P_W-1:0]  p_approx,
  output stage1_t         s1
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
    end else if (clr) begin
      s1 <= '0;
    end else begin
      s1.valid <= en;
      if (en) begin
        s1.a  <= a;
        s1.b  <= b;
        s1.ed <= abs_diff(p_exact, p_approx);
      end
    end
  end

endmodule

// File: rtl/mult_error_monitor.sv
// rtl/mult_error_monitor.sv - windowed error statistics of an approximate vs exact 8x8 multiplier
import mult_eval_pkg::*;

module mult_error_monitor #(
  parameter int WINDOW = 65536,
  parameter int CNT_W  = 17,
  parameter int ACC_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  input  logic [P_W-1:0]   p_exact,
  input  logic [P_W-1:0]   p_approx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] sum_ed,
  output logic [P_W-1:0]   max_ed,
  output logic [OP_W-1:0]  max_a,
  output logic [OP_W-1:0]  max_b
);

  // One spare bit above the wider of accumulator and ED so the clamp test never wraps
  localparam int               SUM_W    = ((ACC_W > P_W) ? ACC_W : P_W) + 1;
  localparam logic [SUM_W-1:0] SUM_MAX  = {{(SUM_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

  state_t           state, state_nxt;
  stage1_t          s1;
  logic             accept;
  logic             last_accept;
  logic [SUM_W-1:0] sum_ext;

  // start wins over a same-edge accept, so that sample never enters the pipeline
  assign accept      = in_valid && (state == RUN) && !start;
  assign last_accept = accept && (sample_cnt == LAST_IDX);
  assign sum_ext     = SUM_W'(sum_ed) + SUM_W'(s1.ed);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: ;
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (last_accept) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: done = 1'b1;
      default: state_nxt = IDLE;
    endcase
    if (start) state_nxt = RUN;
  end

  mult_ed_stage u_ed_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (start),
    .en       (accept),
    .a        (a),
    .b        (b),
    .p_exact  (p_exact),
    .p_approx (p_approx),
    .s1       (s1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      sample_cnt <= '0;
    else if (start)  sample_cnt <= '0;
    else if (accept) sample_cnt <= sample_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
      sum_ed  <= '0;
      max_ed  <= '0;
      max_a   <= '0;
      max_b   <= '0;
    end else if (start) begin
      err_cnt <= '0;
      sum_ed  <= '0;
      max_ed  <= '0;
      max_a   <= '0;
      max_b   <= '0;
    end else if (s1.valid) begin
      if (s1.ed != '0) err_cnt <= err_cnt + CNT_W'(1);
      sum_ed <= (sum_ext > SUM_MAX) ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
      // Strictly greater keeps the earliest sample on a tie
      if (s1.ed > max_ed) begin
        max_ed <= s1.ed;
        max_a  <= s1.a;
        max_b  <= s1.b;
      end
    end
  end

endmodule

// File: tb/tb_mult_error_monitor.sv
// tb/tb_mult_error_monitor.sv - scoreboard bench for mult_error_monitor over three parameterisations
module tb_mult_error_monitor;

  localparam int N = 3;

  typedef struct {
    int     cnt;
    int     err;
    longint sum;
    int     mx;
    int     ma;
    int     mb;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] start;
  logic         in_valid;
  logic [7:0]   a, b;
  logic [15:0]  p_exact, p_approx;

  wire  [N-1:0] in_ready, busy, done;
  wire  [16:0]  sample_cnt [N];
  wire  [16:0]  err_cnt    [N];
  wire  [31:0]  sum_ed     [N];
  wire  [9:0]   sum_ed2;
  wire  [15:0]  max_ed     [N];
  wire  [7:0]   max_a      [N];
  wire  [7:0]   max_b      [N];

  assign sum_ed[2] = {22'd0, sum_ed2};

  always #5 clk = ~clk;

  mult_error_monitor #(.WINDOW(65536)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .in_valid(in_valid), .in_ready(in_ready[0]),
    .a(a), .b(b), .p_exact(p_exact), .p_approx(p_approx), .busy(busy[0]), .done(done[0]),
    .sample_cnt(sample_cnt[0]), .err_cnt(err_cnt[0]), .sum_ed(sum_ed[0]),
    .max_ed(max_ed[0]), .max_a(max_a[0]), .max_b(max_b[0]));

  mult_error_monitor #(.WINDOW(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .in_valid(in_valid), .in_ready(in_ready[1]),
    .a(a), .b(b), .p_exact(p_exact), .p_approx(p_approx), .busy(busy[1]), .done(done[1]),
    .sample_cnt(sample_cnt[1]), .err_cnt(err_cnt[1]), .sum_ed(sum_ed[1]),
    .max_ed(max_ed[1]), .max_a(max_a[1]), .max_b(max_b[1]));

  mult_error_monitor #(.WINDOW(2), .ACC_W(10)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .in_valid(in_valid), .in_ready(in_ready[2]),
    .a(a), .b(b), .p_exact(p_exact), .p_approx(p_approx), .busy(busy[2]), .done(done[2]),
    .sample_cnt(sample_cnt[2]), .err_cnt(err_cnt[2]), .sum_ed(sum_ed2),
    .max_ed(max_ed[2]), .max_a(max_a[2]), .max_b(max_b[2]));

  int     checks   = 0;
  int     failures = 0;
  int     mst  [N];
  res_t   acc  [N];
  res_t   last_res [N];
  logic   done_q [N];
  logic   took [N];
  res_t   exp_q [$];

  function automatic int win_of(input int k);
    return (k == 0) ? 65536 : (k == 1) ? 4 : 2;
  endfunction

  function automatic longint sat_of(input int k);
    return (k == 2) ? 64'd1023 : 64'hFFFF_FFFF;
  endfunction

  function automatic res_t zero_res();
    res_t r;
    r.cnt = 0; r.err = 0; r.sum = 0; r.mx = 0; r.ma = 0; r.mb = 0;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic cmp_res(input int k, input res_t r);
    chk($sformatf("sample_cnt%0d", k), 64'(sample_cnt[k]), 64'(r.cnt));
    chk($sformatf("err_cnt%0d", k),    64'(err_cnt[k]),    64'(r.err));
    chk($sformatf("sum_ed%0d", k),     64'(sum_ed[k]),     64'(r.sum));
    chk($sformatf("max_ed%0d", k),     64'(max_ed[k]),     64'(r.mx));
    chk($sformatf("max_a%0d", k),      64'(max_a[k]),      64'(r.ma));
    chk($sformatf("max_b%0d", k),      64'(max_b[k]),      64'(r.mb));
  endtask

  task automatic model_edge();
    int ed;
    for (int k = 0; k < N; k++) begin
      took[k] = 1'b0;
      if (start[k]) begin
        mst[k] = 1;
        acc[k] = zero_res();
      end else if (mst[k] == 1) begin
        if (in_valid) begin
          took[k] = 1'b1;
          ed = int'(p_exact) - int'(p_approx);
          if (ed < 0) ed = -ed;
          acc[k].cnt++;
          if (ed != 0) acc[k].err++;
          acc[k].sum = acc[k].sum + ed;
          if (acc[k].sum > sat_of(k)) acc[k].sum = sat_of(k);
          if (ed > acc[k].mx) begin
            acc[k].mx = ed; acc[k].ma = int'(a); acc[k].mb = int'(b);
          end
          if (acc[k].cnt == win_of(k)) begin
            mst[k] = 2;
            exp_q.push_back(acc[k]);
          end
        end
      end else if (mst[k] == 2) begin
        mst[k] = 3;
      end
    end
  endtask

  task automatic tick();
    res_t r;
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("in_ready%0d", k),   64'(in_ready[k]), 64'(mst[k] == 1));
      chk($sformatf("busy%0d", k),       64'(busy[k]), 64'(mst[k] == 1 || mst[k] == 2));
      chk($sformatf("done%0d", k),       64'(done[k]), 64'(mst[k] == 3));
      chk($sformatf("cnt_live%0d", k),   64'(sample_cnt[k]), 64'(acc[k].cnt));
      if (done[k] === 1'b1 && done_q[k] !== 1'b1) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("sb_nonempty%0d", k), 64'd0, 64'd1);
        end else begin
          r = exp_q.pop_front();
          last_res[k] = r;
          cmp_res(k, r);
        end
      end
      done_q[k] = done[k];
    end
  endtask

  task automatic put(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                     input logic [15:0] pe, input logic [15:0] pa);
    in_valid = v; a = ia; b = ib; p_exact = pe; p_approx = pa;
    tick();
  endtask

  task automatic pulse_start(input int k);
    start[k] = 1'b1;
    in_valid = 1'b0;
    tick();
    start[k] = 1'b0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mst[k] = 0; acc[k] = zero_res(); done_q[k] = 1'b0; took[k] = 1'b0;
    end
    exp_q.delete();
  endtask

  task automatic check_zero(input int k);
    chk($sformatf("rst_in_ready%0d", k), 64'(in_ready[k]), 64'd0);
    chk($sformatf("rst_busy%0d", k),     64'(busy[k]), 64'd0);
    chk($sformatf("rst_done%0d", k),     64'(done[k]), 64'd0);
    cmp_res(k, zero_res());
  endtask

  initial begin
    int idx, cyc;
    logic [7:0] sa, sb;
    rst_n = 1'b0; start = '0; in_valid = 1'b0;
    a = '0; b = '0; p_exact = '0; p_approx = '0;
    model_reset();
    #3;
    for (int k = 0; k < N; k++) check_zero(k);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // WINDOW=4: restart mid-run on an accepting edge, then the reference pairs
    pulse_start(1);
    put(1'b1, 8'd9, 8'd9, 16'd81, 16'd80);
    put(1'b1, 8'd200, 8'd200, 16'd40000, 16'd0);
    start[1] = 1'b1;
    put(1'b1, 8'd255, 8'd255, 16'd65025, 16'd0);
    start[1] = 1'b0;
    put(1'b1, 8'd3, 8'd5, 16'd15, 16'd15);
    put(1'b0, 8'd99, 8'd99, 16'd1, 16'd60000);
    put(1'b1, 8'd7, 8'd7, 16'd49, 16'd48);
    put(1'b1, 8'd255, 8'd255, 16'd65025, 16'd64000);
    put(1'b1, 8'd2, 8'd2, 16'd4, 16'd6);
    for (int i = 0; i < 6; i++) put(1'b1, 8'd200, 8'd1, 16'd5000, 16'd0);
    cmp_res(1, last_res[1]);
    chk("ref_cnt", 64'(sample_cnt[1]), 64'd4);
    chk("ref_err", 64'(err_cnt[1]), 64'd3);
    chk("ref_sum", 64'(sum_ed[1]), 64'd1028);
    chk("ref_max", 64'(max_ed[1]), 64'd1025);
    chk("ref_max_a", 64'(max_a[1]), 64'd255);
    chk("ref_max_b", 64'(max_b[1]), 64'd255);

    // WINDOW=2, ACC_W=10: tie on max, then saturation after a DONE->RUN restart
    pulse_start(2);
    put(1'b1, 8'd1, 8'd1, 16'd1, 16'd9);
    put(1'b1, 8'd2, 8'd2, 16'd4, 16'd12);
    for (int i = 0; i < 3; i++) put(1'b0, 8'd0, 8'd0, 16'd0, 16'd0);
    chk("tie_max_a", 64'(max_a[2]), 64'd1);
    chk("tie_max_b", 64'(max_b[2]), 64'd1);
    pulse_start(2);
    put(1'b1, 8'd0, 8'd0, 16'd1000, 16'd0);
    put(1'b1, 8'd0, 8'd0, 16'd0, 16'd100);
    for (int i = 0; i < 3; i++) put(1'b0, 8'd0, 8'd0, 16'd0, 16'd0);
    chk("sat_sum", 64'(sum_ed[2]), 64'd1023);
    chk("sat_err", 64'(err_cnt[2]), 64'd2);

    // Reset mid-run after 10 accepts
    pulse_start(0);
    for (int i = 0; i < 10; i++)
      put(1'b1, 8'(i + 1), 8'(i + 2), 16'd500, 16'(i));
    rst_n = 1'b0;
    model_reset();
    #2;
    for (int k = 0; k < N; k++) check_zero(k);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Exhaustive sweep with random in_valid gaps
    pulse_start(0);
    idx = 0;
    cyc = 0;
    while (idx < 65536 && cyc < 90000) begin
      sa = 8'(idx >> 8);
      sb = 8'(idx);
      put(($urandom_range(0, 15) != 0), sa, sb, 16'(sa * sb), 16'((sa & 8'hFC) * sb));
      if (took[0]) idx++;
      cyc++;
    end
    if (idx < 65536) chk("sweep_budget", 64'(idx), 64'd65536);
    for (int i = 0; i < 3; i++) put(1'b1, 8'd0, 8'd0, 16'd0, 16'd0);
    chk("sweep_cnt", 64'(sample_cnt[0]), 64'd65536);
    chk("sweep_max_a", 64'(max_a[0]), 64'd3);
    chk("sweep_max_b", 64'(max_b[0]), 64'd255);
    for (int i = 0; i < 4; i++) put(1'($urandom_range(0, 1)), 8'd1, 8'd1, 16'd9, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_error_monitor.md
# mult_error_monitor

Downstream evaluation stage for the 8x8 multipliers. It consumes operand/product pairs from the exact multiplier and an approximate multiplier driven by the same operands. Over a programmable window of samples it accumulates the error statistics used to characterise each approximate design: error count, sum of error distance and maximum error distance with the operands that caused it. Results are held until the next run is started.

## Interface
- `WINDOW`, default 65536: samples per run (1..2^CNT_W-1); 65536 covers an exhaustive 8x8 sweep.
- `CNT_W`, default 17: width of the sample and error counters.
- `ACC_W`, default 32: width of the error-distance sum accumulator.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; clears all results and begins a run.
- `in_valid` in 1: a sample is presented.
- `in_ready` out 1: the block accepts a sample (high only in RUN).
- `a`, `b` in 8 each: operands of the sample.
- `p_exact` in 16: exact product.
- `p_approx` in 16: approximate product.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: high in DONE; results are valid and stable.
- `sample_cnt` out CNT_W: number of accepted samples.
- `err_cnt` out CNT_W: number of samples with p_exact != p_approx.
- `sum_ed` out ACC_W: saturating sum of |p_exact - p_approx|.
- `max_ed` out 16: largest error distance seen.
- `max_a`, `max_b` out 8 each: operands of the first sample that reached `max_ed`.

## Operation
- FSM states are IDLE, RUN, DRAIN and DONE; the reset state is IDLE.
- IDLE -> RUN on `start`.
- RUN -> DRAIN on the edge that accepts sample number WINDOW.
- DRAIN -> DONE unconditionally after one cycle.
- DONE -> RUN on `start`.
- `start` in RUN or DRAIN restarts: results clear, the pipeline is flushed, and the state goes to RUN.
- Accept happens when `in_valid && in_ready`. On accept, `sample_cnt` increments and stage 1 captures `a`, `b`, a valid flag and ED = |p_exact - p_approx|. ED is computed with a 17-bit signed subtract and is always <= 16 bits.
- Stage 2, the cycle after stage 1 is valid:
  - `err_cnt` += (ED != 0).
  - `sum_ed` += ED, clamped at 2^ACC_W-1, with no wrap.
  - If ED > `max_ed` (strictly greater), `max_ed`, `max_a` and `max_b` update. On a tie the earlier sample is kept.
- The clear on `start` zeroes `sample_cnt`, `err_cnt`, `sum_ed`, `max_ed`, `max_a`, `max_b` and the stage-1 valid flag. `start` has priority over any accept on the same edge; that sample is dropped.
- `in_valid` outside RUN is ignored. Operand and product inputs are don't-care when `in_valid` is low.
- Results stay frozen in DONE and IDLE.

## Timing
- Reset values: state IDLE, `in_ready`=0, `busy`=0, `done`=0, and every count, accumulator, max field and stage-1 register is 0.
- `in_ready` goes high the cycle after the `start` edge.
- Throughput is one sample per cycle.
- Latency from an accept edge to that sample's effect on `err_cnt`, `sum_ed` or `max_*` is one further edge. `sample_cnt` is visible after the accept edge itself.
- `done` rises on the edge after the accepting edge of the final sample, together with the final stage-2 update. All outputs are final in the first cycle `done` is high.
- `in_ready` drops on the final accepting edge; there is no overshoot past WINDOW.
- Asserting `rst_n` low mid-run returns the block to reset values immediately; no partial results are kept.

## Structure
- Package `mult_eval_pkg` holds:
  - `OP_W`=8 and `P_W`=16;
  - the FSM state enum (IDLE, RUN, DRAIN, DONE);
  - a stage-1 struct {valid, a, b, ed}.
- Sub-module `mult_ed_stage`: the registered |p_exact - p_approx| stage with its valid flag, operand capture and synchronous clear. It is reused by future per-bit error monitors.
- The top level holds the FSM, counters and accumulators.

## Test plan
- Reset mid-run: after 10 samples accepted, pulse `rst_n` low -> all outputs 0, state IDLE, `in_ready`=0; then a `start` begins a clean run.
- WINDOW=4 with pairs (3,5,15,15), (7,7,49,48), (255,255,65025,64000), (2,2,4,6):
  - `done` on the edge after the 4th accept;
  - `sample_cnt`=4, `err_cnt`=3, `sum_ed`=1028, `max_ed`=1025, `max_a`=255, `max_b`=255.
- Tie on max: ED values 8, 8 at operands (1,1) then (2,2) -> `max_a`=1, `max_b`=1.
- Saturation with ACC_W=10, WINDOW=2, ED values 1000 and 100 -> `sum_ed`=1023, `err_cnt`=2.
- Flow control:
  - `in_valid` toggled randomly across an exhaustive sweep with WINDOW=65536 -> `sample_cnt`=65536, and `in_ready` is never high after the last accept;
  - `in_valid` held high in DONE -> no counter change.
- Restart with `start` pulsed during RUN on the same cycle as an accept -> that sample is dropped and counters restart at 0.
